mdm_uart_loopback_engine: RTL and testbench
===========================================

# mdm_uart_loopback_engine

Parametrised AXI-Stream byte-processing loopback core placed between the UART RX wrapper output and the UART TX wrapper input of the MDM FTDI test top. It replaces the direct RX-to-TX wire with a FIFO-buffered path that supports runtime-selectable echo modes, line-buffered release, traffic counters and a stretched activity LED.

## Interface
- DATA_W, 8, byte width of both streams.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- TERM_BYTE, 8'h0D, line terminator for LINE mode.
- CNT_W, 16, width of each traffic counter.
- LED_STRETCH, 2500000, LED on-time in CLOCK cycles after each accepted byte; ≥1.
- CLOCK  in  1  single clock domain; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MODE  in  2  0=PASS, 1=LINE, 2=INVERT, 3=DISCARD.
- s_tdata  in  DATA_W  byte from RX wrapper.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  DATA_W  byte to TX wrapper.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- rx_count  out  CNT_W  accepted input bytes, all modes.
- tx_count  out  CNT_W  completed output handshakes.
- drop_count  out  CNT_W  bytes discarded in DISCARD mode.
- LED  out  1  activity indicator.

## Operation
- Reset: FIFO empty, state PASS, active mode = 0; s_tready=0, m_tvalid=0, m_tdata=0, all counters 0, LED=0.
- Active mode register: MODE is sampled into the active mode only while FIFO is empty and state ≠ DRAIN; otherwise the previous mode holds.
- FIFO: circular buffer, write/read pointers of log2(FIFO_DEPTH)+1 bits (wrap bit distinguishes full/empty). m_tdata reads the head entry combinationally. A push while full or a pop while empty never occurs.
- PASS: s_tready = !full; m_tvalid = !empty; bytes are stored unchanged.
- INVERT: as PASS, but each byte is stored as ~s_tdata.
- LINE, state FILL: s_tready = !full; m_tvalid=0. On accepting TERM_BYTE, or on a push that makes the FIFO full → DRAIN.
- LINE, state DRAIN: s_tready=0; m_tvalid = !empty; on the pop that empties the FIFO → FILL.
- DISCARD: s_tready=1 once the FIFO is empty (bytes already queued are drained first with m_tvalid=!empty). Accepted bytes are not stored; drop_count increments.
- States: PASS (used by modes 0, 2, 3), FILL, DRAIN. Leaving LINE for another mode occurs only from FILL with FIFO empty.
- Counters: rx_count +1 per s handshake; tx_count +1 per m handshake; drop_count +1 per DISCARD handshake. All wrap modulo 2^CNT_W.
- LED: a down-counter is loaded with LED_STRETCH on every s handshake and decrements to 0 otherwise; LED = (counter ≠ 0).

## Timing
- Latency in PASS/INVERT: byte accepted at edge N → m_tvalid=1 and m_tdata valid in the cycle after edge N.
- Simultaneous push and pop: allowed when neither full nor empty; occupancy unchanged. When full, s_tready=0 in the same cycle, even if a pop is occurring.
- m_tdata/m_tvalid remain stable while m_tvalid=1 and m_tready=0.
- LINE: the terminator is included in the released data. FILL→DRAIN occurs at the edge accepting the terminator, and the first byte is presented in the next cycle.
- Counters update at the handshake edge. The LED rises in the cycle after the first handshake.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously), and queued bytes are lost.

## Test plan
- PASS, send 0x41,0x42,0x43 with m_tready=1 → same bytes out, each 1 cycle after acceptance; rx_count=tx_count=3.
- INVERT, send 0x00,0xA5 → output 0xFF,0x5A.
- LINE, send "AB" then 0x0D with m_tready=1 → no m_tvalid until 0x0D accepted; then 0x41,0x42,0x0D out; s_tready=0 during the drain.
- LINE, FIFO_DEPTH=16, send 16 bytes with no terminator → forced DRAIN after the 16th byte; all 16 are output in order; return to FILL.
- PASS with m_tready=0, push 17 bytes → s_tready falls after 16; raise m_tready → 16 bytes out, then the 17th is accepted; verify pointer wrap over 3 fills.
- DISCARD, send 5 bytes → none out, drop_count=5, rx_count=5. With LED_STRETCH=4, LED is high for 4 cycles after the last byte. Assert RESET_N=0 mid-stream → all outputs are 0 immediately.

Source files
------------

// File: rtl/mdm_uart_loopback_engine.sv
// FIFO-buffered byte loopback between the UART RX and TX AXI-Stream wrappers.
// It supports pass, line-buffered, invert and discard modes, traffic counters and a stretched activity LED.
module mdm_uart_loopback_engine #(
    parameter int                DATA_W      = 8,
    parameter int                FIFO_DEPTH  = 16,
    parameter logic [DATA_W-1:0] TERM_BYTE   = 'h0D,
    parameter int                CNT_W       = 16,
    parameter int                LED_STRETCH = 2500000
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              LED,
    output logic [1:0]        dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(LED_STRETCH + 1);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_LINE    = 2'd1;
    localparam logic [1:0] MODE_INVERT  = 2'd2;
    localparam logic [1:0] MODE_DISCARD = 2'd3;

    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      LVL_LAST = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LW-1:0]    LED_LOAD = LW'(LED_STRETCH);
    localparam logic [LW-1:0]    LED_ONE  = LW'(1);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_mode;
    logic              r_run;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [LW-1:0]     r_led_cnt;

    logic              w_empty;
    logic              w_full;
    logic [AW:0]       w_level;
    logic              w_discard;
    logic              w_sample;
    logic              w_s_ready;
    logic              w_m_valid;
    logic              w_s_hs;
    logic              w_m_hs;
    logic              w_push;
    logic [DATA_W-1:0] w_wdata;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_discard = (r_state == ST_PASS) && (r_mode == MODE_DISCARD);
    // The active mode only follows MODE when nothing is queued and no line is being released.
    assign w_sample  = w_empty && (r_state != ST_DRAIN);

    // Handshakes: a byte moves on a stream only at a rising edge where valid and ready are both high.
    always_comb begin
        w_s_ready   = 1'b0;
        w_m_valid   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_PASS: begin
                w_m_valid = !w_empty;
                w_s_ready = w_discard ? w_empty : !w_full;
            end
            ST_FILL:  w_s_ready = !w_full;
            ST_DRAIN: w_m_valid = !w_empty;
            default: ;
        endcase
        if (!r_run) begin
            w_s_ready = 1'b0;
        end

        w_s_hs = s_tvalid && w_s_ready;
        w_m_hs = w_m_valid && m_tready;
        w_push = w_s_hs && !w_discard;

        case (r_state)
            ST_FILL: begin
                if (w_push && ((s_tdata == TERM_BYTE) || (w_level == LVL_LAST))) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_sample) begin
                    w_state_nxt = (MODE == MODE_LINE) ? ST_FILL : ST_PASS;
                end
            end
            ST_DRAIN: begin
                if (w_m_hs && (w_level == PTR_ONE)) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                if (w_sample) begin
                    w_state_nxt = (MODE == MODE_LINE) ? ST_FILL : ST_PASS;
                end
            end
        endcase
    end

    assign w_wdata = ((r_state == ST_PASS) && (r_mode == MODE_INVERT)) ? ~s_tdata : s_tdata;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_PASS;
            r_mode     <= MODE_PASS;
            r_run      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_drop_cnt <= '0;
            r_led_cnt  <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (w_sample) begin
                r_mode <= MODE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_m_hs) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_tx_cnt <= r_tx_cnt + CNT_ONE;
            end
            if (w_s_hs) begin
                r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
            if (w_s_hs && w_discard) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
            if (w_s_hs) begin
                r_led_cnt <= LED_LOAD;
            end else if (r_led_cnt != '0) begin
                r_led_cnt <= r_led_cnt - LED_ONE;
            end
        end
    end

    // Storage is not reset: the pointers alone decide what is valid.
    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
        end
    end

    assign s_tready   = w_s_ready;
    assign m_tvalid   = w_m_valid;
    assign m_tdata    = w_m_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign rx_count   = r_rx_cnt;
    assign tx_count   = r_tx_cnt;
    assign drop_count = r_drop_cnt;
    assign LED        = (r_led_cnt != '0);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mdm_uart_loopback_engine.sv
// Directed-plus-random bench for mdm_uart_loopback_engine.
// It holds a queue-based reference model of the bytes that should appear at the TX side.
module tb_mdm_uart_loopback_engine;

    localparam int LED_ST = 4;

    logic        clk;
    logic        RESET_N;
    logic [1:0]  MODE;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [15:0] drop_count;
    logic        LED;
    logic [1:0]  dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         rx_exp = 0;
    int         tx_exp = 0;
    int         drop_exp = 0;
    int         model_mode = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;

    mdm_uart_loopback_engine #(
        .DATA_W(8), .FIFO_DEPTH(16), .TERM_BYTE(8'h0D), .CNT_W(16), .LED_STRETCH(LED_ST)
    ) dut (
        .CLOCK(clk), .RESET_N(RESET_N), .MODE(MODE),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count),
        .LED(LED), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge, when inputs are settled for the coming rising edge.
    task automatic observe();
        logic [7:0] e;
        if (hold_prev) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, hold_data);
        end
        if (m_tvalid && m_tready) begin
            chk("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("m_tdata", m_tdata, e);
            end
            tx_exp++;
        end
        if (s_tvalid && s_tready) begin
            rx_exp++;
            if (model_mode == 3) drop_exp++;
            else if (model_mode == 2) exp_q.push_back(~s_tdata);
            else exp_q.push_back(s_tdata);
        end
        hold_prev = m_tvalid && !m_tready;
        hold_data = m_tdata;
    endtask

    task automatic cycle();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1;
            acc = s_tready;
            observe();
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || m_tvalid); i++) cycle();
        chk("drain_done", (exp_q.size() == 0) && !m_tvalid, 1);
    endtask

    task automatic chk_counts();
        chk("rx_count", rx_count, rx_exp[15:0]);
        chk("tx_count", tx_count, tx_exp[15:0]);
        chk("drop_count", drop_count, drop_exp[15:0]);
    endtask

    function automatic logic [7:0] rand_nonterm();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D) b = 8'h0E;
        return b;
    endfunction

    initial begin
        logic [1:0] fill_code;
        logic [7:0] b17;

        RESET_N = 1'b1; MODE = 2'd0; s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b0;
        #1 RESET_N = 1'b0;
        #2;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk_counts();
        chk("rst_led", LED, 0);
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        idle(2);

        // PASS: three bytes, one-cycle latency
        m_tready = 1'b1;
        send(8'h41);
        #1;
        chk("pass_latency_valid", m_tvalid, 1);
        chk("pass_latency_data", m_tdata, exp_q[0]);
        send(8'h42);
        send(8'h43);
        drain();
        chk_counts();
        chk("pass_rx3", rx_count, 3);

        // INVERT
        MODE = 2'd2; idle(2); model_mode = 2;
        send(8'h00);
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)));
        drain();

        // LINE: "AB" + terminator
        MODE = 2'd1; idle(2); model_mode = 1;
        send(8'h41);
        #1 chk("line_hold_a", m_tvalid, 0);
        fill_code = dbg_state;
        send(8'h42);
        #1 chk("line_hold_b", m_tvalid, 0);
        send(8'h0D);
        #1;
        chk("line_drain_rdy", s_tready, 0);
        chk("line_drain_vld", m_tvalid, 1);
        chk("line_state_moved", dbg_state != fill_code, 1);
        for (int i = 0; i < 10 && m_tvalid; i++) begin
            chk("line_drain_rdy_loop", s_tready, 0);
            cycle();
        end
        chk("line_empty", exp_q.size(), 0);
        #1;
        chk("line_refill_rdy", s_tready, 1);
        chk("line_refill_vld", m_tvalid, 0);
        chk("line_state_back", dbg_state, fill_code);

        // LINE: 16 bytes with no terminator force a release
        for (int i = 0; i < 16; i++) begin
            send(rand_nonterm());
            #1 chk("line_full_vld", m_tvalid, (i == 15));
        end
        chk("line_full_rdy", s_tready, 0);
        for (int i = 0; i < 40 && m_tvalid; i++) cycle();
        chk("line_full_empty", exp_q.size(), 0);
        #1 chk("line_full_refill", s_tready, 1);

        // PASS with back-pressure: three full fills wrap the pointers
        MODE = 2'd0; idle(2); model_mode = 0;
        for (int f = 0; f < 3; f++) begin
            m_tready = 1'b0;
            for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
            b17 = 8'($urandom_range(0, 255));
            s_tdata = b17; s_tvalid = 1'b1;
            #1;
            chk("full_rdy", s_tready, 0);
            chk("full_vld", m_tvalid, 1);
            @(negedge clk);
            m_tready = 1'b1;
            #1 chk("full_pop_rdy", s_tready, 0);
            send(b17);
            drain();
        end
        chk_counts();

        // PASS random traffic
        for (int i = 0; i < 300; i++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = 8'($urandom_range(0, 255));
            m_tready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        s_tvalid = 1'b0;
        drain();
        chk_counts();

        // DISCARD: queued bytes drain first, then five bytes vanish
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
        MODE = 2'd3;
        idle(3);
        drain();
        idle(2); model_mode = 3;
        drop_exp = 0;
        chk("discard_start_drop", drop_count, 0);
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom_range(0, 255)));
            #1 chk("discard_no_out", m_tvalid, 0);
        end
        @(negedge clk);
        chk("discard_drop5", drop_count, 5);
        chk_counts();

        // Re-synchronise right after the last accepted byte for the LED window
        send(8'h77);
        for (int k = 0; k <= LED_ST; k++) begin
            chk("led_stretch", LED, (k < LED_ST));
            @(negedge clk);
        end

        // Reset in the middle of a transfer
        MODE = 2'd0; idle(2); model_mode = 0;
        m_tready = 1'b0;
        send(8'h11);
        send(8'h22);
        s_tdata = 8'h33; s_tvalid = 1'b1;
        #3 RESET_N = 1'b0;
        #1;
        chk("mid_rst_s_tready", s_tready, 0);
        chk("mid_rst_m_tvalid", m_tvalid, 0);
        chk("mid_rst_m_tdata", m_tdata, 0);
        chk("mid_rst_led", LED, 0);
        exp_q.delete();
        rx_exp = 0; tx_exp = 0; drop_exp = 0;
        hold_prev = 1'b0;
        chk_counts();
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        m_tready = 1'b1;
        send(8'h5C);
        drain();
        chk_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
